// File: rtl/armleocpu_mem_1rwm_ctrl.sv
// ---------------------------------------------------------------------------
// armleocpu_mem_1rwm_ctrl
//
// Initiator-side controller for a single-port, byte-write-enabled synchronous
// memory. The memory is read-first, has a 1-cycle read latency, and holds its
// read data until the next read. The controller turns a request channel and a
// response channel into the memory's address/read/write strobes. After reset
// it can zero-fill the whole array before it accepts any request.
//
// Handshake rules (both channels):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer that raises valid keeps it high, with its payload stable,
//   until the transfer. ready may depend combinationally on the other side:
//   req_ready follows resp_ready in RESP, which gives one request per cycle.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_*             request channel: valid/ready, write flag, word address,
//                     per-lane write enable, write data
//   resp_*            response channel: valid/ready, echoed write flag,
//                     read data (combinational pass-through of mem_readdata)
//   init_done         high once the clear sequence has finished
//   mem_*             strobes to and data from the storage array
//   dbg_state         current FSM state, for checkers and debug
// ---------------------------------------------------------------------------
module armleocpu_mem_1rwm_ctrl #(
  parameter int ELEMENTS_W = 7,
  parameter int WIDTH      = 32,
  parameter int GRANULITY  = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ELEMENTS_W-1:0]         req_address,
  input  logic [WIDTH/GRANULITY-1:0]    req_writeenable,
  input  logic [WIDTH-1:0]              req_writedata,

  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_write,
  output logic [WIDTH-1:0]              resp_readdata,

  output logic                          init_done,

  output logic [ELEMENTS_W-1:0]         mem_address,
  output logic                          mem_read,
  input  logic [WIDTH-1:0]              mem_readdata,
  output logic                          mem_write,
  output logic [WIDTH/GRANULITY-1:0]    mem_writeenable,
  output logic [WIDTH-1:0]              mem_writedata,

  output logic [1:0]                    dbg_state
);

  localparam int LANES    = WIDTH / GRANULITY;
  localparam int ELEMENTS = 2 ** ELEMENTS_W;
  localparam logic [ELEMENTS_W-1:0] LAST_ADDRESS = ELEMENTS_W'(ELEMENTS - 1);

  // A partial lane would leave data bits with no write enable.
  if ((WIDTH % GRANULITY) != 0) begin : g_bad_granularity
    $fatal(1, "WIDTH must be a multiple of GRANULITY");
  end

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [ELEMENTS_W-1:0]   clear_counter;
  logic                    accept;

  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Request side. In RESP a new request can only be taken while the current
  // response is being consumed, because the memory read port would otherwise
  // overwrite the data still presented on resp_readdata. Nothing is accepted
  // while rst is high so that a request cannot slip into a reset cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  req_ready = 1'b1;
        S_RESP:  req_ready = resp_ready;
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign accept = req_valid && req_ready;

  // -------------------------------------------------------------------------
  // Memory strobes. Address/data/enable default to the request payload; they
  // are don't-care unless mem_read or mem_write is high. The strobes are
  // forced low during rst so no stray write reaches the array.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_address     = req_address;
    mem_writeenable = req_writeenable;
    mem_writedata   = req_writedata;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    if (!rst) begin
      if (state == S_INIT) begin
        mem_address     = clear_counter;
        mem_writeenable = {LANES{1'b1}};
        mem_writedata   = '0;
        mem_write       = 1'b1;
      end else if (accept) begin
        mem_read  = !req_write;
        mem_write = req_write;
      end
    end
  end

  // The memory holds its read data until the next read, and no read is
  // issued while a response stalls, so a plain pass-through is stable.
  assign resp_readdata = mem_readdata;

  // -------------------------------------------------------------------------
  // Control FSM with registered response and init status.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT_CLEAR ? S_INIT : S_IDLE;
      clear_counter <= '0;
      resp_valid    <= 1'b0;
      resp_write    <= 1'b0;
      init_done     <= !INIT_CLEAR;
    end else begin
      case (state)
        S_INIT: begin
          // The counter wraps back to 0 on the last address, so the clear
          // takes exactly ELEMENTS cycles with no extra turn-around cycle.
          clear_counter <= clear_counter + 1'b1;
          if (clear_counter == LAST_ADDRESS) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end

        S_IDLE: begin
          if (accept) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_write <= req_write;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            if (accept) begin
              // Back-to-back: the next response follows immediately.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_write <= req_write;
            end else begin
              state      <= S_IDLE;
              resp_valid <= 1'b0;
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_mem_1rwm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_armleocpu_mem_1rwm_ctrl
//
// Directed bench for armleocpu_mem_1rwm_ctrl with default parameters
// (128 x 32-bit words, 8-bit lanes, clear after reset). A behavioural
// read-first memory with byte lanes sits on the mem_* side. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_armleocpu_mem_1rwm_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_address;
  logic [3:0]  req_writeenable;
  logic [31:0] req_writedata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_write;
  logic [31:0] resp_readdata;
  logic        init_done;
  logic [6:0]  mem_address;
  logic        mem_read;
  logic [31:0] mem_readdata;
  logic        mem_write;
  logic [3:0]  mem_writeenable;
  logic [31:0] mem_writedata;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  armleocpu_mem_1rwm_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_address     (req_address),
    .req_writeenable (req_writeenable),
    .req_writedata   (req_writedata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_write      (resp_write),
    .resp_readdata   (resp_readdata),
    .init_done       (init_done),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_readdata    (mem_readdata),
    .mem_write       (mem_write),
    .mem_writeenable (mem_writeenable),
    .mem_writedata   (mem_writedata),
    .dbg_state       (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_array [0:127];

  always @(posedge clk) begin
    if (mem_read) mem_readdata <= mem_array[mem_address];
    if (mem_write) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_writeenable[l]) mem_array[mem_address][l*8 +: 8] <= mem_writedata[l*8 +: 8];
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic wr, input logic [6:0] a, input logic [3:0] we,
                           input logic [31:0] d);
    req_valid       = 1'b1;
    req_write       = wr;
    req_address     = a;
    req_writeenable = we;
    req_writedata   = d;
  endtask

  // Runs from one falling edge: issues a request, checks the accept cycle,
  // then checks the response in the next cycle. Ends on a falling edge.
  task automatic single(input string tag, input logic wr, input logic [6:0] a,
                        input logic [3:0] we, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    @(posedge clk); #1;
    drive_req(wr, a, we, d);
    resp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_mem_read"},  32'(mem_read),  32'(!wr));
    check({tag, "_mem_write"}, 32'(mem_write), 32'(wr));
    check({tag, "_mem_addr"},  32'(mem_address), 32'(a));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_resp_write"}, 32'(resp_write), 32'(wr));
    if (!wr) check({tag, "_rdata"}, resp_readdata, exp_rd);
  endtask

  // Starts right after the first INIT cycle begins; checks 128 clear writes.
  task automatic init_sweep(input string tag);
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      check({tag, "_wr"},    32'(mem_write), 32'd1);
      check({tag, "_rd"},    32'(mem_read), 32'd0);
      check({tag, "_addr"},  32'(mem_address), 32'(i));
      check({tag, "_data"},  mem_writedata, 32'd0);
      check({tag, "_we"},    32'(mem_writeenable), 32'hF);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_done"},  32'(init_done), 32'd0);
      check({tag, "_resp"},  32'(resp_valid), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_address     = '0;
    req_writeenable = '0;
    req_writedata   = '0;
    resp_ready      = 1'b1;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_write", 32'(resp_write), 32'd0);
    check("rst_init_done",  32'(init_done), 32'd0);
    check("rst_mem_write",  32'(mem_write), 32'd0);
    check("rst_req_ready",  32'(req_ready), 32'd0);

    // A read of 0x55 is offered through the whole clear and must survive it.
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1'b0, 7'h55, 4'h0, 32'h0);
    init_sweep("init1");

    // Cycle 129: init done and the held request is accepted.
    @(negedge clk);
    check("init1_done_rise", 32'(init_done), 32'd1);
    check("rd55_accept",     32'(req_ready), 32'd1);
    check("rd55_mem_read",   32'(mem_read), 32'd1);
    check("rd55_mem_write",  32'(mem_write), 32'd0);
    check("rd55_addr",       32'(mem_address), 32'h55);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rd55_resp_valid", 32'(resp_valid), 32'd1);
    check("rd55_resp_write", 32'(resp_write), 32'd0);
    check("rd55_rdata",      resp_readdata, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd55_idle", 32'(resp_valid), 32'd0);

    // Lane merge.
    single("wr5_full", 1'b1, 7'd5, 4'hF, 32'h11223344, 32'h0);
    single("wr5_part", 1'b1, 7'd5, 4'b0101, 32'hAABBCCDD, 32'h0);
    single("rd5",      1'b0, 7'd5, 4'h0, 32'h0, 32'h11BB33DD);

    // Preload.
    single("pre1", 1'b1, 7'd1, 4'hF, 32'hA1, 32'h0);
    single("pre2", 1'b1, 7'd2, 4'hF, 32'hA2, 32'h0);
    single("pre3", 1'b1, 7'd3, 4'hF, 32'hA3, 32'h0);

    // Zero write-enable write: response still returned, no lane changes.
    single("wr1_we0", 1'b1, 7'd1, 4'h0, 32'hFFFFFFFF, 32'h0);
    single("rd1_we0", 1'b0, 7'd1, 4'h0, 32'h0, 32'hA1);

    // Back-to-back reads 1, 2, 3.
    @(posedge clk); #1;
    drive_req(1'b0, 7'd1, 4'h0, 32'h0);
    @(negedge clk);
    check("b2b_ready0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(1'b0, 7'd2, 4'h0, 32'h0);
    @(negedge clk);
    check("b2b_ready1", 32'(req_ready), 32'd1);
    check("b2b_valid1", 32'(resp_valid), 32'd1);
    check("b2b_data1",  resp_readdata, 32'hA1);
    @(posedge clk); #1;
    drive_req(1'b0, 7'd3, 4'h0, 32'h0);
    @(negedge clk);
    check("b2b_ready2", 32'(req_ready), 32'd1);
    check("b2b_valid2", 32'(resp_valid), 32'd1);
    check("b2b_data2",  resp_readdata, 32'hA2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid3", 32'(resp_valid), 32'd1);
    check("b2b_data3",  resp_readdata, 32'hA3);

    // Stall: read 2, hold resp_ready low 3 cycles with read 3 pending.
    @(posedge clk); #1;
    drive_req(1'b0, 7'd2, 4'h0, 32'h0);
    @(negedge clk);
    check("stall_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    drive_req(1'b0, 7'd3, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_rd",    32'(mem_read), 32'd0);
      check("stall_data",  resp_readdata, 32'hA2);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("unstall_ready", 32'(req_ready), 32'd1);
    check("unstall_rd",    32'(mem_read), 32'd1);
    check("unstall_addr",  32'(mem_address), 32'd3);
    check("unstall_data",  resp_readdata, 32'hA2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("unstall_valid", 32'(resp_valid), 32'd1);
    check("unstall_data3", resp_readdata, 32'hA3);
    @(posedge clk); #1;
    @(negedge clk);
    check("unstall_idle", 32'(resp_valid), 32'd0);

    // Read directly after write to the same address.
    @(posedge clk); #1;
    drive_req(1'b1, 7'd7, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    check("raw_wr_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(1'b0, 7'd7, 4'h0, 32'h0);
    @(negedge clk);
    check("raw_rd_accept", 32'(req_ready), 32'd1);
    check("raw_wr_resp",   32'(resp_write), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("raw_rd_resp",  32'(resp_write), 32'd0);
    check("raw_rd_data",  resp_readdata, 32'hDEADBEEF);

    // Reset with a stalled response pending: response is dropped.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    drive_req(1'b0, 7'd3, 4'h0, 32'h0);
    @(negedge clk);
    check("drop_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;

    // Let the clear reach address 40, then reset again for one cycle.
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("mid_addr40", 32'(mem_address), 32'd40);
    check("mid_no_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    init_sweep("init2");
    @(negedge clk);
    check("init2_done_rise", 32'(init_done), 32'd1);
    check("init2_no_write",  32'(mem_write), 32'd0);
    check("init2_resp",      32'(resp_valid), 32'd0);

    // The clear really zeroed previously written data.
    single("rd5_cleared", 1'b0, 7'd5, 4'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
